// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable clock divider with burst length, graceful stop
// and configuration staged to take effect at half-period boundaries
module clk_div_ctrl #(
   parameter int          WIDTH        = 32,
   parameter int unsigned DEFAULT_HALF = 4999999,
   parameter int          BW           = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_half,
   input  logic [BW-1:0]    cfg_burst,
   output logic             cfg_ready,
   output logic             clk_out,
   output logic             tick,
   output logic             running,
   output logic             done,
   output logic [BW-1:0]    periods
);

   localparam logic [WIDTH-1:0] RST_HALF = WIDTH'(DEFAULT_HALF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] cntr, cntr_nx;
   logic [WIDTH-1:0] act_half, act_half_nx;
   logic [WIDTH-1:0] pend_half, pend_half_nx;
   logic [BW-1:0]    act_burst, act_burst_nx;
   logic [BW-1:0]    pend_burst, pend_burst_nx;
   logic [BW-1:0]    periods_nx, periods_inc;
   logic             pend_flag, pend_flag_nx;
   logic             clk_out_nx, tick_nx, done_nx, running_nx, cfg_ready_nx;
   logic             accept, term, fall, burst_end, to_idle;

   assign periods_inc = periods + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cntr       <= '0;
         clk_out    <= 1'b0;
         tick       <= 1'b0;
         done       <= 1'b0;
         running    <= 1'b0;
         periods    <= '0;
         cfg_ready  <= 1'b1;
         act_half   <= RST_HALF;
         act_burst  <= '0;
         pend_half  <= '0;
         pend_burst <= '0;
         pend_flag  <= 1'b0;
      end else begin
         state      <= state_nx;
         cntr       <= cntr_nx;
         clk_out    <= clk_out_nx;
         tick       <= tick_nx;
         done       <= done_nx;
         running    <= running_nx;
         periods    <= periods_nx;
         cfg_ready  <= cfg_ready_nx;
         act_half   <= act_half_nx;
         act_burst  <= act_burst_nx;
         pend_half  <= pend_half_nx;
         pend_burst <= pend_burst_nx;
         pend_flag  <= pend_flag_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      cntr_nx       = cntr;
      clk_out_nx    = clk_out;
      tick_nx       = 1'b0;
      done_nx       = 1'b0;
      periods_nx    = periods;
      act_half_nx   = act_half;
      act_burst_nx  = act_burst;
      pend_half_nx  = pend_half;
      pend_burst_nx = pend_burst;
      pend_flag_nx  = pend_flag;
      to_idle       = 1'b0;
      accept        = cfg_valid && cfg_ready;
      term          = (state != IDLE) && (cntr == act_half);
      fall          = term && clk_out;
      burst_end     = fall && (act_burst != '0) && (periods_inc == act_burst);

      case (state)
         IDLE: begin
            cntr_nx    = '0;
            clk_out_nx = 1'b0;
            if (start && !stop) begin
               state_nx   = RUN;
               periods_nx = '0;
            end
         end
         RUN, STOP: begin
            if (term) begin
               cntr_nx    = '0;
               clk_out_nx = !clk_out;
               tick_nx    = 1'b1;
            end else begin
               cntr_nx = cntr + 1'b1;
            end
            if (fall) begin
               periods_nx = periods_inc;
            end
            if (state == RUN && stop && !clk_out) begin
               // Stopping in the low phase ends at once; a rise due now is suppressed.
               to_idle    = 1'b1;
               clk_out_nx = 1'b0;
               tick_nx    = 1'b0;
            end else if (fall && (state == STOP || stop || burst_end)) begin
               to_idle = 1'b1;
            end else if (state == RUN && stop) begin
               state_nx = STOP;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (to_idle) begin
         state_nx = IDLE;
         cntr_nx  = '0;
         done_nx  = 1'b1;
      end

      // A staged config lands at a half-period boundary or when the run ends.
      if (pend_flag && (term || to_idle)) begin
         act_half_nx  = pend_half;
         act_burst_nx = pend_burst;
         pend_flag_nx = 1'b0;
      end

      if (accept) begin
         if (state == IDLE || to_idle) begin
            act_half_nx  = cfg_half;
            act_burst_nx = cfg_burst;
         end else begin
            pend_half_nx  = cfg_half;
            pend_burst_nx = cfg_burst;
            pend_flag_nx  = 1'b1;
         end
      end

      running_nx   = (state_nx != IDLE);
      cfg_ready_nx = !pend_flag_nx;
   end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, width of the half-period compare value and counter.
REQ-002 Parameter DEFAULT_HALF, default 4999999, reset value of the active half-period terminal count.
REQ-003 Parameter BW, default 16, width of burst length and period counter.
REQ-004 Port clk  input  1  sole clock; all state changes on posedge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port start  input  1  request to begin generating clk_out.
REQ-007 Port stop  input  1  request to end generation at the next low phase.
REQ-008 Port cfg_valid  input  1  config offer; accepted when cfg_valid and cfg_ready are both 1 at a posedge.
REQ-009 Port cfg_half  input  WIDTH  new terminal count; half-period = cfg_half+1 clk cycles.
REQ-010 Port cfg_burst  input  BW  full periods per run; 0 = free-run.
REQ-011 Port cfg_ready  output  1  controller can accept a config.
REQ-012 Port clk_out  output  1  divided clock, registered.
REQ-013 Port tick  output  1  one-cycle pulse, high in the same cycle clk_out shows a new value.
REQ-014 Port running  output  1  high in RUN and STOP states.
REQ-015 Port done  output  1  one-cycle pulse on entry to IDLE from RUN or STOP.
REQ-016 Port periods  output  BW  completed full periods since last start.

Function
REQ-017 FSM states: IDLE, RUN, STOP; all outputs registered.
REQ-018 Active regs: act_half (reset DEFAULT_HALF), act_burst (reset 0); pending regs pend_half, pend_burst, pend_flag (reset 0).
REQ-019 IDLE: cntr=0, clk_out=0, tick=0, running=0; config accepted loads act_half/act_burst directly next cycle; cfg_ready=1.
REQ-020 RUN/STOP: config accepted goes to pend regs, pend_flag=1; cfg_ready=!pend_flag.
REQ-021 Counting (RUN/STOP): cntr != act_half -> cntr+1; cntr == act_half -> cntr=0, clk_out toggles, tick=1.
REQ-022 Pending config applies in the toggle cycle: the half-period just ended uses the old act_half, the next one uses pend_half. pend_flag clears then, and cfg_ready returns to 1 on the next cycle.
REQ-023 act_half=0 -> clk_out toggles every cycle (period 2 clk).
REQ-024 start in IDLE -> RUN, with cntr=0 and periods=0. First rising clk_out comes act_half+1 cycles after the start edge; period is 2*(act_half+1).
REQ-025 periods increments on every 1->0 toggle; it wraps modulo 2^BW in free-run.
REQ-026 Burst end: act_burst!=0 and a 1->0 toggle makes periods equal act_burst -> IDLE, done=1.
REQ-027 stop in RUN, clk_out=0 -> IDLE next cycle, done=1, no partial high phase emitted.
REQ-028 stop in RUN, clk_out=1 -> STOP; counting continues; the next 1->0 toggle -> IDLE, done=1.
REQ-029 start and stop in the same cycle: stop wins. start in RUN/STOP is ignored. stop in IDLE is ignored. stop in STOP is ignored.
REQ-030 On any entry to IDLE, a still-pending config moves into the act regs and pend_flag clears.
REQ-031 cfg_valid and a terminal toggle in the same cycle: the pend regs are written. The new values apply at the following toggle, not the current one.

Reset
REQ-032 rst_n low, at any time including mid-period, immediately forces all of the following:
- state=IDLE, cntr=0, clk_out=0, tick=0, done=0, running=0, periods=0
- cfg_ready=1, pend_flag=0, act_half=DEFAULT_HALF, act_burst=0
- any pending config is discarded.
REQ-033 After rst_n rises, no toggle occurs until a start is accepted.

Verification (DEFAULT_HALF=3 for sim)
REQ-034 Reset, then start pulse -> running=1 next cycle; clk_out rises 4 cycles after the start edge; tick pulses every 4 cycles; periods=1 after 8 cycles.
REQ-035 In IDLE, cfg_half=0, cfg_burst=3, then start -> clk_out toggles every cycle; after 6 cycles periods=3, done=1 for one cycle, clk_out=0, running=0.
REQ-036 Free-run with half=3; cfg_half=1 offered mid high phase -> cfg_ready=0 until the toggle; the current half stays 4 cycles long, later halves are 2 cycles long; cfg_ready=1 the cycle after.
REQ-037 stop while clk_out=1, 1 cycle into the high phase -> STOP; the high phase completes (3 more cycles), then done=1 and IDLE. Repeat with stop while clk_out=0 -> IDLE next cycle.
REQ-038 start and stop asserted together in RUN -> stop behaviour only; start and stop in IDLE -> no state change.
REQ-039 rst_n low for 1 cycle in the middle of a burst with a config pending -> all outputs reach reset values asynchronously; act_half=3, pend discarded, and no tick occurs after release.
